// File: rtl/i2s_tx_stream_if.sv
// Sample stream handshake into the I2S transmitter.
// The producer drives din/din_tvalid, the sink returns din_tready.
interface i2s_tx_stream_if #(
  parameter int DIN_WIDTH = 32
);
  logic [DIN_WIDTH-1:0] din;
  logic                 din_tvalid;
  logic                 din_tready;

  modport master (
    output din,
    output din_tvalid,
    input  din_tready
  );

  modport slave (
    input  din,
    input  din_tvalid,
    output din_tready
  );
endinterface

// File: rtl/i2s_tx_stream.sv
// I2S transmitter: 2-entry sample buffer, mono sample sent in both
// slots, one-bit I2S delay, zero-fill and counting on underflow.
module i2s_tx_stream #(
  parameter int DIN_WIDTH    = 32,
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_BITS    = 32,
  parameter int BCLK_DIV     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  i2s_tx_stream_if.slave s,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  localparam int FRAME = 2 * SLOT_BITS;
  localparam int BW = $clog2(FRAME);
  localparam int KW = $clog2(SLOT_BITS);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int IW = (DIN_WIDTH > 1) ? $clog2(DIN_WIDTH) : 1;

  logic [DW-1:0]        div_cnt;
  logic                 div_tc;
  logic                 fall;
  logic [BW-1:0]        bit_cnt;
  logic [BW-1:0]        nxt_bit;
  logic [BW-1:0]        kf;
  logic [KW-1:0]        k;
  logic [IW-1:0]        idx;
  logic                 tx_bit;
  logic                 frame_start;
  logic [DIN_WIDTH-1:0] frame_reg;
  logic [DIN_WIDTH-1:0] mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic                 push;
  logic                 pop;

  assign div_tc = (div_cnt == DW'(BCLK_DIV - 1));
  assign fall   = div_tc && i2s_bclk;

  assign s.din_tready = rst_n && (count != 2'd2);
  assign push = s.din_tvalid && s.din_tready;
  assign pop  = frame_start && (count != 2'd0);

  // Next slot position and the bit it carries; the sample sits at
  // positions 1..SAMPLE_WIDTH, taken from the top of the stored word.
  always_comb begin
    nxt_bit = (bit_cnt == BW'(FRAME - 1)) ? '0 : bit_cnt + BW'(1);
    kf = (nxt_bit >= BW'(SLOT_BITS)) ?
         nxt_bit - BW'(SLOT_BITS) : nxt_bit;
    k = kf[KW-1:0];
    idx = IW'(DIN_WIDTH) - IW'(k);
    tx_bit = 1'b0;
    if (k != '0 && k <= KW'(SAMPLE_WIDTH))
      tx_bit = frame_reg[idx];
    frame_start = fall && (nxt_bit == '0);
  end

  // Bit clock divider: toggle bclk every BCLK_DIV clk cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (div_tc) begin
      div_cnt  <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Serial side: advance slot position and shift data on falling bclk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
    end else if (fall) begin
      bit_cnt   <= nxt_bit;
      i2s_lrclk <= (nxt_bit >= BW'(SLOT_BITS));
      i2s_sdata <= tx_bit;
    end
  end

  // Input buffer: push on handshake, pop at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s.din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Frame load: take the buffer head, or zero-fill and flag underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_reg     <= '0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      underflow <= 1'b0;
      if (frame_start) begin
        if (count != 2'd0) begin
          frame_reg <= mem[rd_ptr];
        end else begin
          frame_reg <= '0;
          underflow <= 1'b1;
          if (underflow_cnt != 16'hFFFF)
            underflow_cnt <= underflow_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_stream.sv
// Bench for i2s_tx_stream: directed stimulus, expected frame words
// queued at push time and checked by a serial-side monitor.
module tb_i2s_tx_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bclk, lrclk, sdata, uf;
  logic [15:0] uf_cnt;

  always #5 clk = ~clk;

  i2s_tx_stream_if #(.DIN_WIDTH(32)) bus ();

  i2s_tx_stream dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s             (bus),
    .i2s_bclk      (bclk),
    .i2s_lrclk     (lrclk),
    .i2s_sdata     (sdata),
    .underflow     (uf),
    .underflow_cnt (uf_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Monitor state
  int          pos = 0;
  int          mk;
  logic        pb = 1'b0, plr = 1'b0, psd = 1'b0;
  logic [23:0] wl = '0, wr = '0;
  bit          pad_e = 0, lr_e = 0, st_e = 0;

  function automatic void frame_done();
    logic [23:0] e;
    checks++;
    if (lr_e) begin
      errors++;
      $display("FAIL lrclk_align got misaligned want aligned");
    end
    checks++;
    if (pad_e || st_e) begin
      errors++;
      $display("FAIL pad_or_stray got pad=%0d stray=%0d want 0 0",
               pad_e, st_e);
    end
    checks++;
    if (wl !== wr) begin
      errors++;
      $display("FAIL lr_equal got %h want %h", wr, wl);
    end
    if (wl != 0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_word got %h want none", wl);
      end else begin
        e = exp_q.pop_front();
        if (wl !== e) begin
          errors++;
          $display("FAIL frame_word got %h want %h", wl, e);
        end
      end
    end
    wl = '0; wr = '0;
    pad_e = 0; lr_e = 0; st_e = 0;
  endfunction

  // Serial monitor: decode bits on falling bclk
  always @(negedge clk) begin
    if (!rst_n) begin
      pos = 0; pb = 0; plr = 0; psd = 0;
      wl = '0; wr = '0;
      pad_e = 0; lr_e = 0; st_e = 0;
    end else begin
      if (pb && !bclk) begin
        pos = (pos + 1) % 64;
        if (pos == 0) frame_done();
        if (lrclk !== (pos >= 32)) lr_e = 1;
        mk = pos % 32;
        if (mk >= 1 && mk <= 24) begin
          if (pos < 32) wl[24-mk] = sdata;
          else          wr[24-mk] = sdata;
        end else if (sdata !== 1'b0) begin
          pad_e = 1;
        end
      end else if (sdata !== psd || lrclk !== plr) begin
        st_e = 1;
      end
      pb = bclk; plr = lrclk; psd = sdata;
    end
  end

  task automatic push(input logic [31:0] v);
    int n;
    bus.din = v;
    bus.din_tvalid = 1'b1;
    n = 0;
    while (!bus.din_tready && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!bus.din_tready) chk("push_timeout", 0, 1);
    @(posedge clk);
    #1 bus.din_tvalid = 1'b0;
  endtask

  task automatic wait_fs();
    logic p;
    int n;
    bit ok;
    p = lrclk; n = 0; ok = 0;
    while (n < 600 && !ok) begin
      @(negedge clk);
      n++;
      if (p && !lrclk) ok = 1;
      p = lrclk;
    end
    if (!ok) chk("frame_start_timeout", 0, 1);
  endtask

  initial begin
    logic p;
    int n;
    bus.din = '0;
    bus.din_tvalid = 1'b0;
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_uf", uf, 0);
    chk("rst_ufcnt", uf_cnt, 0);
    chk("rst_tready", bus.din_tready, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("tready_idle", bus.din_tready, 1);
    repeat (3) @(posedge clk);
    #1 chk("bclk_e3", bclk, 0);
    @(posedge clk);
    #1 chk("bclk_e4", bclk, 1);
    repeat (3) @(posedge clk);
    #1 chk("bclk_e7", bclk, 1);
    @(posedge clk);
    #1 chk("bclk_e8", bclk, 0);

    // Single sample
    @(negedge clk);
    exp_q.push_back(24'h123456);
    push(32'h12345678);
    wait_fs();
    chk("uf_f1", uf, 0);

    // Backpressure: A, B accepted, C waits for the next pop
    exp_q.push_back(24'hA1B2C3);
    exp_q.push_back(24'h5E6F70);
    exp_q.push_back(24'h0F1E2D);
    bus.din = 32'hA1B2C3D4;
    bus.din_tvalid = 1'b1;
    @(posedge clk);
    #1 bus.din = 32'h5E6F7081;
    @(posedge clk);
    #1 bus.din = 32'h0F1E2D3C;
    @(negedge clk);
    chk("bp_full", bus.din_tready, 0);
    p = lrclk; n = 0;
    while (n < 600) begin
      @(negedge clk);
      n++;
      if (bus.din_tready) break;
      p = lrclk;
    end
    chk("bp_pop_align", {29'd0, p, lrclk, bus.din_tready}, 32'd5);
    @(posedge clk);
    #1 bus.din_tvalid = 1'b0;
    wait_fs();
    chk("uf_f3", uf, 0);
    wait_fs();
    chk("uf_f4", uf, 0);
    chk("ufcnt_f4", uf_cnt, 0);

    // Underflow for three frames
    for (int i = 1; i <= 3; i++) begin
      wait_fs();
      chk("uf_pulse", uf, 1);
      chk("uf_count", uf_cnt, i);
    end
    @(negedge clk);
    chk("uf_width", uf, 0);
    exp_q.push_back(24'h800000);
    push(32'h80000000);
    wait_fs();
    chk("uf_f8", uf, 0);
    chk("ufcnt_f8", uf_cnt, 3);
    wait_fs();
    chk("uf_f9", uf, 1);
    chk("ufcnt_f9", uf_cnt, 4);

    // Mid-frame reset with two samples buffered
    push(32'hDEADBEEF);
    push(32'h01234567);
    chk("mid_full", bus.din_tready, 0);
    p = bclk; n = 0;
    for (int c = 0; c < 600 && n < 40; c++) begin
      @(negedge clk);
      if (p && !bclk) n++;
      p = bclk;
    end
    chk("mid_falls", n, 40);
    chk("mid_lrclk_pre", lrclk, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_bclk", bclk, 0);
    chk("mid_lrclk", lrclk, 0);
    chk("mid_sdata", sdata, 0);
    chk("mid_ufcnt", uf_cnt, 0);
    chk("mid_tready", bus.din_tready, 0);
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_fs();
    chk("post_uf", uf, 1);
    chk("post_ufcnt", uf_cnt, 1);
    wait_fs();
    chk("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
